psub32_pipe: RTL and testbench

- Pipelined WIDTH-bit subtract-with-borrow unit: d = a - b - bin, with borrow-out bout.
- It is the inverse datapath of the pipelined 32-bit adder (pfa32). Feeding it pfa32's sum as a, together with the same b and cin as bin, recovers pfa32's original a.
- Split into STAGES equal chunks. Each stage resolves one chunk, with borrow rippling stage-to-stage.
- Uses a valid/ready handshake with backpressure and sits downstream of pfa32 in the ALU datapath.

---
 rtl/psub32_pipe_if.sv | 38 +++
 rtl/psub32_pipe.sv | 88 ++++++++
 tb/tb_psub32_pipe.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psub32_pipe_if.sv
// Operand/result handshake bundle for psub32_pipe.
// Carries ovf when PSUB32_PIPE_OVF_EN is defined.
interface psub32_pipe_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             out_valid;
  logic             out_ready;
`ifdef PSUB32_PIPE_OVF_EN
  logic             ovf;

  modport slave (
    input  a, b, bin, in_valid, out_ready,
    output in_ready, d, bout, out_valid, ovf
  );

  modport master (
    output a, b, bin, in_valid, out_ready,
    input  in_ready, d, bout, out_valid, ovf
  );
`else
  modport slave (
    input  a, b, bin, in_valid, out_ready,
    output in_ready, d, bout, out_valid
  );

  modport master (
    output a, b, bin, in_valid, out_ready,
    input  in_ready, d, bout, out_valid
  );
`endif
endinterface

// File: rtl/psub32_pipe.sv
// Pipelined subtract-with-borrow, one CW-bit chunk per stage.
// Optional signed overflow output: PSUB32_PIPE_OVF_EN.
module psub32_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic          clk,
  input logic          rst,
  psub32_pipe_if.slave s
);
  localparam int CW = WIDTH / STAGES;

  typedef logic [STAGES-1:0][WIDTH-1:0] wvec_t;
  typedef logic [STAGES-2:0][WIDTH-1:0] opvec_t;

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] brw_q, brw_d;
  wvec_t             r_q, r_d;
  opvec_t            a_q, b_q;

  wvec_t             src_a, src_b, src_r;
  logic [STAGES-1:0] src_br, src_v;

  // Element k is what stage k consumes: the inputs for k=0,
  // otherwise the registers of stage k-1.
  assign src_a  = {a_q, s.a};
  assign src_b  = {b_q, s.b};
  assign src_r  = {r_q[STAGES-2:0], {WIDTH{1'b0}}};
  assign src_br = {brw_q[STAGES-2:0], s.bin};
  assign src_v  = {vld_q[STAGES-2:0], s.in_valid};

  assign adv        = !vld_q[STAGES-1] || s.out_ready;
  assign s.in_ready = adv && !rst;
  assign s.out_valid = vld_q[STAGES-1];
  assign s.d         = r_q[STAGES-1];
  assign s.bout      = brw_q[STAGES-1];

  always_comb begin
    logic [CW:0] t;
    t     = '0;
    r_d   = src_r;
    brw_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, src_a[k][k*CW +: CW]}
        - {1'b0, src_b[k][k*CW +: CW]}
        - (CW+1)'(src_br[k]);
      r_d[k][k*CW +: CW] = t[CW-1:0];
      brw_d[k]           = t[CW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      brw_q <= '0;
      r_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (adv) begin
      vld_q <= src_v;
      brw_q <= brw_d;
      r_q   <= r_d;
      a_q   <= src_a[STAGES-2:0];
      b_q   <= src_b[STAGES-2:0];
    end
  end

`ifdef PSUB32_PIPE_OVF_EN
  logic ovf_q, ovf_d;

  // Borrow into the MSB is recovered as d^a^b at that bit.
  assign ovf_d = r_d[STAGES-1][WIDTH-1]
               ^ src_a[STAGES-1][WIDTH-1]
               ^ src_b[STAGES-1][WIDTH-1]
               ^ brw_d[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign s.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_psub32_pipe.sv
// Self-checking bench for psub32_pipe: vector table, corner
// sequences and randomized traffic against a queue model.
module tb_psub32_pipe;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        bout;
    logic        ovf;
    int          t;
  } exp_t;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -MAXS - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psub32_pipe_if #(.WIDTH(32)) bus ();

  psub32_pipe #(
    .WIDTH (32),
    .STAGES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nacc = 0;
  int ndel = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  int last_lat = 0;
  logic [31:0] last_d = '0;
  logic last_bout = 1'b0;
  logic last_ovf = 1'b0;
  exp_t sb[$];
  vec_t vt[7];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                 logic bin);
    exp_t e;
    logic [32:0] f;
    longint sd;
    f  = {1'b0, a} - {1'b0, b} - 33'(bin);
    sd = longint'(signed'(a)) - longint'(signed'(b)) - longint'(bin);
    e.d    = f[31:0];
    e.bout = f[32];
    e.ovf  = (sd > MAXS) || (sd < MINS);
    e.t    = 0;
    return e;
  endfunction

  // One clock window: sample handshakes before the edge, then step.
  task automatic cycle();
    exp_t e;
    #1;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", bus.out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("sb_d", bus.d, e.d);
          chk("sb_bout", bus.bout, e.bout);
`ifdef PSUB32_PIPE_OVF_EN
          chk("sb_ovf", bus.ovf, e.ovf);
          last_ovf = bus.ovf;
`endif
          prev_cyc  = last_cyc;
          last_cyc  = cyc;
          last_lat  = cyc - e.t;
          last_d    = bus.d;
          last_bout = bus.bout;
          ndel++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.a, bus.b, bus.bin);
        e.t = cyc;
        sb.push_back(e);
        nacc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(string nm, int max);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max) begin
      cycle();
      n++;
    end
    chk(nm, sb.size(), 0);
  endtask

  task automatic put(vec_t v);
    bus.a = v.a;
    bus.b = v.b;
    bus.bin = v.bin;
    bus.in_valid = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold;
    int k0;
    int a0;

    vt[0] = '{32'hFFFFFFFF, 32'hFF00FF00, 1'b0, 32'h00FF00FF, 1'b0, 1'b0};
    vt[1] = '{32'h00000000, 32'h0C00FF00, 1'b1, 32'hF3FF00FF, 1'b1, 1'b0};
    vt[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[3] = '{32'h00010000, 32'h00000000, 1'b1, 32'h0000FFFF, 1'b0, 1'b0};
    vt[4] = '{32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[5] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vt[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};

    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Reset, with a valid input offered that must be ignored.
    cycle();
    cycle();
    #1;
    chk("rst_d", bus.d, 32'h0);
    chk("rst_bout", bus.bout, 1'b0);
    chk("rst_ov", bus.out_valid, 1'b0);
    chk("rst_irdy", bus.in_ready, 1'b0);
`ifdef PSUB32_PIPE_OVF_EN
    chk("rst_ovf", bus.ovf, 1'b0);
`endif
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_irdy", bus.in_ready, 1'b1);

    // Vector table, one isolated transaction each.
    foreach (vt[i]) begin
      put(vt[i]);
      bus.out_ready = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      drain($sformatf("vec%0d_timeout", i), 10);
      chk($sformatf("vec%0d_d", i), last_d, vt[i].d);
      chk($sformatf("vec%0d_bout", i), last_bout, vt[i].bout);
`ifdef PSUB32_PIPE_OVF_EN
      chk($sformatf("vec%0d_ovf", i), last_ovf, vt[i].ovf);
`endif
      chk($sformatf("vec%0d_lat", i), last_lat, 4);
      #1;
      chk($sformatf("vec%0d_once", i), bus.out_valid, 1'b0);
    end

    // Back-to-back pair.
    k0 = ndel;
    put(vt[0]);
    cycle();
    put(vt[1]);
    cycle();
    bus.in_valid = 1'b0;
    drain("b2b_timeout", 10);
    chk("b2b_cnt", ndel - k0, 2);
    chk("b2b_gap", last_cyc - prev_cyc, 1);
    chk("b2b_last_d", last_d, vt[1].d);

    // Backpressure: fill four, stall three cycles, release.
    k0 = ndel;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a = $urandom;
      bus.b = $urandom;
      bus.bin = 1'($urandom);
      bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    hold = bus.d;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_irdy", bus.in_ready, 1'b0);
      chk("stall_ov", bus.out_valid, 1'b1);
      chk("stall_d", bus.d, hold);
      cycle();
    end
    bus.out_ready = 1'b1;
    drain("bp_timeout", 12);
    chk("bp_cnt", ndel - k0, 4);
    chk("bp_gap", last_cyc - prev_cyc, 1);

    // Reset one cycle after two accepts.
    bus.a = $urandom;
    bus.b = $urandom;
    bus.in_valid = 1'b1;
    cycle();
    bus.a = $urandom;
    cycle();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_irdy", bus.in_ready, 1'b0);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("mid_rst_ov", bus.out_valid, 1'b0);
      cycle();
    end
    put(vt[1]);
    cycle();
    bus.in_valid = 1'b0;
    drain("post_rst_timeout", 10);
    chk("post_rst_d", last_d, vt[1].d);
    chk("post_rst_lat", last_lat, 4);

    // Randomized traffic with random backpressure.
    k0 = ndel;
    a0 = nacc;
    for (int i = 0; i < 400; i++) begin
      bus.a = $urandom;
      bus.b = (i % 5 == 0) ? bus.a : $urandom;
      bus.bin = 1'($urandom);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand_timeout", 20);
    chk("rand_cnt", ndel - k0, nacc - a0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
